instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 103 ++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC, instruction register, RAM address/write muxing and field decode.
// Optional macro FETCH_BRANCH_EN enables the loadbr PC-relative branch (pc+1+sximm8).
module instr_fetch #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            loadir,
  input  logic            loadpc,
  input  logic            msel,
  input  logic            mwrite,
  input  logic [1:0]      nsel,
  input  logic            loadbr,
  input  logic [15:0]     mdata,
  input  logic [PC_W-1:0] dp_addr,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_write,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     ir,
  output logic            ir_valid,
  output logic [2:0]      opcode,
  output logic [1:0]      op,
  output logic [1:0]      shift,
  output logic [2:0]      readnum,
  output logic [2:0]      writenum,
  output logic [15:0]     sximm5,
  output logic [15:0]     sximm8
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            ir_valid_q, ir_valid_d;
  logic [2:0]      reg_num;

  assign mem_addr  = msel ? dp_addr : pc_q;
  assign mem_write = mwrite & msel;

  assign pc       = pc_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign shift  = ir_q[4:3];
  assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};
  assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};

  always_comb begin
    reg_num = 3'd0;
    case (nsel)
      2'b00:   reg_num = ir_q[10:8];
      2'b01:   reg_num = ir_q[7:5];
      2'b10:   reg_num = ir_q[2:0];
      default: reg_num = 3'd0;
    endcase
  end

  assign readnum  = reg_num;
  assign writenum = reg_num;

  always_comb begin
    // NOTE: every next-state signal defaults to its current value first, so no path can infer a latch.
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    // IR samples mdata addressed by the current (pre-increment) PC.
    if (loadir) begin
      ir_d       = mdata;
      ir_valid_d = 1'b1;
    end
`ifdef FETCH_BRANCH_EN
    if (loadbr) begin
      pc_d = pc_q + PC_W'(1) + sximm8[PC_W-1:0];
    end else if (loadpc) begin
      pc_d = pc_q + PC_W'(1);
    end
`else
    if (loadpc) begin
      pc_d = pc_q + PC_W'(1);
    end
`endif
  end

`ifndef FETCH_BRANCH_EN
  logic unused_loadbr;
  assign unused_loadbr = loadbr;
`endif

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so all registers update from pre-edge values.
    if (reset) begin
      pc_q       <= RESET_PC;
      ir_q       <= 16'h0000;
      ir_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

endmodule
